// File: rtl/instr_decoder.sv
// instr_decoder: single-cycle registered instruction decoder for the CGRA
// front end. Each 32-bit word is split into fields according to the format
// selected by its 3-bit opcode. Every word is decoded on its own.
// Optional feature: define DECODER_ILLEGAL_EN to add the registered
// 'illegal' output flagging opcodes 110 and 111.
module instr_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [2:0]  op,
  output logic [1:0]  prefix,
  output logic [3:0]  funct,
  output logic [6:0]  nalloc,
  output logic        endF,
  output logic        immab,
  output logic [5:0]  immlo,
  output logic [25:0] immhi,
  output logic [9:0]  offset,
  output logic [5:0]  ta1,
  output logic [5:0]  ta2,
  output logic [5:0]  ta3,
  output logic [5:0]  ta4,
  output logic [1:0]  tt1,
  output logic [1:0]  tt2,
  output logic [1:0]  tt3,
  output logic [1:0]  tt4
`ifdef DECODER_ILLEGAL_EN
  ,
  output logic        illegal
`endif
);

  typedef enum logic [2:0] {
    OP_ALU   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_STORE = 3'b010,
    OP_TPFX  = 3'b011,
    OP_IPFX  = 3'b100,
    OP_FRAG  = 3'b101
  } opcode_e;

  logic [2:0]  d_op;
  logic [1:0]  d_prefix;
  logic [3:0]  d_funct;
  logic [6:0]  d_nalloc;
  logic        d_endf;
  logic        d_immab;
  logic [5:0]  d_immlo;
  logic [25:0] d_immhi;
  logic [9:0]  d_offset;
  logic [5:0]  d_ta1, d_ta2, d_ta3, d_ta4;
  logic [1:0]  d_tt1, d_tt2, d_tt3, d_tt4;
  logic        d_illegal;

  // Decode the current word; every field not used by the format stays 0
  always_comb begin
    d_op      = instruction[31:29];
    d_prefix  = '0;
    d_funct   = '0;
    d_nalloc  = '0;
    d_endf    = 1'b0;
    d_immab   = 1'b0;
    d_immlo   = '0;
    d_immhi   = '0;
    d_offset  = '0;
    d_ta1     = '0;
    d_ta2     = '0;
    d_ta3     = '0;
    d_ta4     = '0;
    d_tt1     = '0;
    d_tt2     = '0;
    d_tt3     = '0;
    d_tt4     = '0;
    d_illegal = 1'b0;
    case (instruction[31:29])
      OP_ALU, OP_LOAD: begin
        d_funct  = instruction[28:25];
        d_immab  = instruction[24];
        d_immlo  = instruction[23:18];
        d_prefix = instruction[17:16];
        d_tt1    = instruction[15:14];
        d_ta1    = instruction[13:8];
        d_tt2    = instruction[7:6];
        d_ta2    = instruction[5:0];
      end
      OP_STORE: begin
        d_funct  = instruction[28:25];
        d_immab  = instruction[24];
        d_immlo  = instruction[23:18];
        d_offset = instruction[9:0];
      end
      OP_TPFX: begin
        d_tt3 = instruction[15:14];
        d_ta3 = instruction[13:8];
        d_tt4 = instruction[7:6];
        d_ta4 = instruction[5:0];
      end
      OP_IPFX: begin
        d_immhi = instruction[25:0];
      end
      OP_FRAG: begin
        d_endf   = instruction[28];
        d_nalloc = instruction[6:0];
      end
      default: begin
        d_illegal = 1'b1;
      end
    endcase
  end

  // Output registers; reset clears everything, including op, and wins over decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op     <= '0;
      prefix <= '0;
      funct  <= '0;
      nalloc <= '0;
      endF   <= 1'b0;
      immab  <= 1'b0;
      immlo  <= '0;
      immhi  <= '0;
      offset <= '0;
      ta1    <= '0;
      ta2    <= '0;
      ta3    <= '0;
      ta4    <= '0;
      tt1    <= '0;
      tt2    <= '0;
      tt3    <= '0;
      tt4    <= '0;
    end else begin
      op     <= d_op;
      prefix <= d_prefix;
      funct  <= d_funct;
      nalloc <= d_nalloc;
      endF   <= d_endf;
      immab  <= d_immab;
      immlo  <= d_immlo;
      immhi  <= d_immhi;
      offset <= d_offset;
      ta1    <= d_ta1;
      ta2    <= d_ta2;
      ta3    <= d_ta3;
      ta4    <= d_ta4;
      tt1    <= d_tt1;
      tt2    <= d_tt2;
      tt3    <= d_tt3;
      tt4    <= d_tt4;
    end
  end

`ifdef DECODER_ILLEGAL_EN
  // Registered invalid-opcode flag, aligned with the other outputs
  always_ff @(posedge clk) begin
    if (!rst_n) illegal <= 1'b0;
    else        illegal <= d_illegal;
  end
`else
  logic unused_illegal;
  assign unused_illegal = d_illegal;
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: directed test-plan vectors plus randomized words and
// resets, checked every cycle against an arithmetic model of the decoder.
module tb_instr_decoder;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  prefix;
    logic [3:0]  funct;
    logic [6:0]  nalloc;
    logic        endf;
    logic        immab;
    logic [5:0]  immlo;
    logic [25:0] immhi;
    logic [9:0]  offset;
    logic [5:0]  ta1, ta2, ta3, ta4;
    logic [1:0]  tt1, tt2, tt3, tt4;
    logic        illegal;
  } dec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [2:0]  op;
  logic [1:0]  prefix;
  logic [3:0]  funct;
  logic [6:0]  nalloc;
  logic        endF;
  logic        immab;
  logic [5:0]  immlo;
  logic [25:0] immhi;
  logic [9:0]  offset;
  logic [5:0]  ta1, ta2, ta3, ta4;
  logic [1:0]  tt1, tt2, tt3, tt4;
  logic        illegal;

  int checks = 0;
  int errors = 0;
  bit running = 0;

  instr_decoder dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction),
    .op(op), .prefix(prefix), .funct(funct), .nalloc(nalloc), .endF(endF),
    .immab(immab), .immlo(immlo), .immhi(immhi), .offset(offset),
    .ta1(ta1), .ta2(ta2), .ta3(ta3), .ta4(ta4),
    .tt1(tt1), .tt2(tt2), .tt3(tt3), .tt4(tt4)
`ifdef DECODER_ILLEGAL_EN
    , .illegal(illegal)
`endif
  );

`ifndef DECODER_ILLEGAL_EN
  assign illegal = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field n bits wide starting at bit lo, by plain division/modulo
  function automatic int unsigned fld(input int unsigned w, input int lo, input int n);
    return (w >> lo) % (32'd1 << n);
  endfunction

  // Reference decoder written from the format table
  function automatic dec_t model(input bit rstn, input logic [31:0] word);
    dec_t e;
    int unsigned u;
    int unsigned opc;
    e = '0;
    u = word;
    opc = u / 32'h2000_0000;
    if (!rstn) return e;
    e.op = 3'(opc);
    if (opc <= 2) begin
      e.funct = 4'(fld(u, 25, 4));
      e.immab = 1'(fld(u, 24, 1));
      e.immlo = 6'(fld(u, 18, 6));
    end
    if (opc <= 1) begin
      e.prefix = 2'(fld(u, 16, 2));
      e.tt1 = 2'(fld(u, 14, 2));
      e.ta1 = 6'(fld(u, 8, 6));
      e.tt2 = 2'(fld(u, 6, 2));
      e.ta2 = 6'(fld(u, 0, 6));
    end else if (opc == 2) begin
      e.offset = 10'(fld(u, 0, 10));
    end else if (opc == 3) begin
      e.tt3 = 2'(fld(u, 14, 2));
      e.ta3 = 6'(fld(u, 8, 6));
      e.tt4 = 2'(fld(u, 6, 2));
      e.ta4 = 6'(fld(u, 0, 6));
    end else if (opc == 4) begin
      e.immhi = 26'(fld(u, 0, 26));
    end else if (opc == 5) begin
      e.endf = 1'(fld(u, 28, 1));
      e.nalloc = 7'(fld(u, 0, 7));
    end else begin
`ifdef DECODER_ILLEGAL_EN
      e.illegal = 1'b1;
`endif
    end
    return e;
  endfunction

  function automatic dec_t dut_vec();
    dec_t g;
    g = '{op: op, prefix: prefix, funct: funct, nalloc: nalloc, endf: endF,
          immab: immab, immlo: immlo, immhi: immhi, offset: offset,
          ta1: ta1, ta2: ta2, ta3: ta3, ta4: ta4,
          tt1: tt1, tt2: tt2, tt3: tt3, tt4: tt4, illegal: illegal};
    return g;
  endfunction

  // Every-cycle comparison of all outputs against the model
  always @(posedge clk) begin
    dec_t expv;
    dec_t got;
    if (running) begin
      expv = model(rst_n, instruction);
      #1;
      got = dut_vec();
      checks++;
      if (got !== expv) begin
        errors++;
        $display("[TB] FAIL cycle_compare instr=%h rst_n=%0b got=%h expected=%h",
                 instruction, rst_n, got, expv);
      end
    end
  end

  task automatic applyStimulus(input bit rstn, input logic [31:0] word);
    @(negedge clk);
    rst_n = rstn;
    instruction = word;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  initial begin
    dec_t m;
    rst_n = 1'b0;
    instruction = 32'hFFFF_FFFF;
    running = 1;

    // Pin the model with hand-decoded literals
    m = model(1'b1, 32'h2BCC95C7);
    checkOutput("model_dload_immlo", 32'(m.immlo), 32'h33);
    checkOutput("model_dload_ta1", 32'(m.ta1), 32'h15);
    m = model(1'b1, 32'h465402CE);
    checkOutput("model_w_offset", 32'(m.offset), 32'h2CE);

    // Reset held with all-ones word
    applyStimulus(1'b0, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 32'hFFFF_FFFF);
    checkOutput("reset_op", 32'(op), 32'h0);
    checkOutput("reset_immhi", 32'(immhi), 32'h0);
    applyStimulus(1'b1, 32'hFFFF_FFFF);
    checkOutput("invalid_op", 32'(op), 32'h7);
    checkOutput("invalid_funct", 32'(funct), 32'h0);
    checkOutput("invalid_immhi", 32'(immhi), 32'h0);
`ifdef DECODER_ILLEGAL_EN
    checkOutput("invalid_illegal", 32'(illegal), 32'h1);
`endif

    // D load
    applyStimulus(1'b1, 32'h2BCC95C7);
    checkOutput("dload_op", 32'(op), 32'h1);
    checkOutput("dload_funct", 32'(funct), 32'h5);
    checkOutput("dload_immab", 32'(immab), 32'h1);
    checkOutput("dload_immlo", 32'(immlo), 32'h33);
    checkOutput("dload_tt1", 32'(tt1), 32'h2);
    checkOutput("dload_ta1", 32'(ta1), 32'h15);
    checkOutput("dload_tt2", 32'(tt2), 32'h3);
    checkOutput("dload_ta2", 32'(ta2), 32'h07);

    // D ALU then W store
    applyStimulus(1'b1, 32'h0254AAFC);
    checkOutput("dalu_ta1", 32'(ta1), 32'h2A);
    checkOutput("dalu_ta2", 32'(ta2), 32'h3C);
    applyStimulus(1'b1, 32'h465402CE);
    checkOutput("w_op", 32'(op), 32'h2);
    checkOutput("w_funct", 32'(funct), 32'h3);
    checkOutput("w_offset", 32'(offset), 32'h2CE);
    checkOutput("w_ta1_cleared", 32'(ta1), 32'h0);
    checkOutput("w_tt2_cleared", 32'(tt2), 32'h0);

    // T and I prefixes
    applyStimulus(1'b1, 32'h6000AAFC);
    checkOutput("t_tt3", 32'(tt3), 32'h2);
    checkOutput("t_ta3", 32'(ta3), 32'h2A);
    checkOutput("t_ta4", 32'(ta4), 32'h3C);
    applyStimulus(1'b1, 32'h82AAAAAA);
    checkOutput("i_op", 32'(op), 32'h4);
    checkOutput("i_immhi", 32'(immhi), 32'h2AAAAAA);

    // Fragment end / start
    applyStimulus(1'b1, 32'hB0000073);
    checkOutput("frag_endf", 32'(endF), 32'h1);
    checkOutput("frag_nalloc", 32'(nalloc), 32'h73);
    applyStimulus(1'b1, 32'hA0000073);
    checkOutput("frag_start_endf", 32'(endF), 32'h0);
    checkOutput("frag_start_nalloc", 32'(nalloc), 32'h73);

    // Reset mid-stream
    applyStimulus(1'b0, 32'h2BCC95C7);
    checkOutput("midreset_op", 32'(op), 32'h0);
    checkOutput("midreset_ta1", 32'(ta1), 32'h0);
    applyStimulus(1'b1, 32'h6000AAFC);
    checkOutput("postreset_op", 32'(op), 32'h3);
    checkOutput("postreset_ta3", 32'(ta3), 32'h2A);

    // Randomized words with occasional reset
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 19) != 0), $urandom);
    end

    @(negedge clk);
    running = 0;
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
